hack_screen_scanout: RTL
========================

// Module: hack_screen_scanout
// PURPOSE
//  Reader side of the Hack screen memory map: fetches 16-bit words from screen RAM and
//  serialises them into a 1-bit pixel stream for video output. Words come from the
//  CPU-written 8K-word screen (512x256, 32 words/line, word bit 0 = leftmost pixel,
//  1 = black). Sits between the screen RAM read port and the video timing generator.
// PARAMETERS
//  ADDR_W     13   screen RAM word-address width
//  LINE_WORDS 32   words fetched per visible line
//  LINES      256  visible lines per frame; line index wraps to 0 after LINES-1
// PORTS
//  clk          in   1       system clock
//  reset_n      in   1       asynchronous, active-low reset
//  frame_start  in   1       one-cycle pulse; line index := 0
//  line_start   in   1       one-cycle pulse before each line's active region
//  pix_ce       in   1       pixel-rate clock enable
//  active       in   1       visible-area enable, sampled with pix_ce
//  mem_req      out  1       read request, held until mem_ack
//  mem_addr     out  ADDR_W  word address, stable while mem_req=1
//  mem_ack      in   1       read data valid on mem_rdata this cycle
//  mem_rdata    in   16      read data
//  pix_out      out  1       pixel, 1 = black
//  pix_valid    out  1       pix_out valid, registered (pix_ce & active)
//  underrun     out  1       sticky; cleared by frame_start
//  underrun_cnt out  8       saturating underrun count (SCANOUT_UNDERRUN_CNT_EN only)
// BEHAVIOUR
//  - Reset: mem_req=0, mem_addr=0, pix_out=0, pix_valid=0, underrun=0, counters/FIFO cleared.
//  - line_start: flush 2-entry FIFO and shift register; fetch_addr := {line_idx,5'b0};
//    words_left := LINE_WORDS; then line_idx := line_idx+1 (mod LINES).
//    frame_start and line_start in the same cycle: frame_start applies first (line 0 used).
//  - Fetch: raise mem_req when words_left>0 and (FIFO count + outstanding) < 2; at most one
//    outstanding. On mem_ack: push mem_rdata (unless discard flag set), fetch_addr+1,
//    words_left-1. mem_ack with mem_req=0 is ignored.
//  - Request pending at line_start: mem_req stays high until mem_ack; that word is discarded
//    and the first fetch for the new line issues the cycle after the ack.
//  - Shifter: on pix_ce & active with bit count 0, load a FIFO word (bit count := 16).
//    Each pix_ce & active: pix_out <= shreg[0], shreg >>= 1, bit count -1. pix_valid is
//    registered pix_ce & active; pixel latency 1 cycle from the pix_ce sample.
//  - FIFO push and pop in the same cycle allowed (count unchanged, FIFO never overflows).
//  - Underrun: load needed and FIFO empty -> pix_out=0 (white) for rest of line, underrun:=1;
//    realigned at next line_start. pix_ce & active after LINE_WORDS*16 pixels -> pix_out=0,
//    no underrun.
//  - reset_n low mid-fetch: everything returns to reset values; a later mem_ack is ignored.
// CONFIGURATION
//  SCANOUT_UNDERRUN_CNT_EN defined: underrun_cnt increments (saturates at 255) on each
//  underrun event, at most once per line; cleared by frame_start and reset.
//  Undefined: underrun_cnt port absent; the sticky underrun flag remains.
// STRUCTURE
//  - Package hack_screen_pkg: SCREEN_W=512, SCREEN_H=256, WORDS_PER_LINE=32, WORD_W=16,
//    pixel polarity constants PIX_BLACK=1/PIX_WHITE=0.
//  - Sub-module hack_word_fifo: 2-entry x 16-bit synchronous FIFO with flush, push, pop,
//    count. Fetch control, line counter and shifter stay in this module.
// TESTING
//  1 Reset: hold reset_n=0 with mem_ack toggling -> all outputs 0, no mem_req.
//  2 Zero-wait RAM, word[0]=16'h0001, word[1]=16'h8000, pix_ce every cycle, line 0 ->
//    pixels 1,0x15 then 0x15,1; mem_addr 0..31; 512 pix_valid; underrun=0.
//  3 Line 5 after frame_start: first mem_addr=160 (5*32); frame_start + line_start same
//    cycle -> mem_addr=0.
//  4 RAM latency 40 cycles, pix_ce every cycle -> underrun=1, pix_out=0 after first
//    starved word; next line_start realigns; frame_start clears underrun.
//  5 line_start while request outstanding, late ack data 16'hFFFF -> word discarded,
//    new line's first fetch issues the cycle after the ack, no 1-pixels from 16'hFFFF.
//  6 With SCANOUT_UNDERRUN_CNT_EN: 300 starved lines -> underrun_cnt=255; frame_start -> 0.

Source files
------------

// File: rtl/hack_screen_pkg.sv
// Shared constants for the Hack screen memory map: geometry, word width and pixel polarity.
package hack_screen_pkg;

  localparam int SCREEN_W       = 512;
  localparam int SCREEN_H       = 256;
  localparam int WORD_W         = 16;
  localparam int WORDS_PER_LINE = SCREEN_W / WORD_W;

  localparam logic PIX_BLACK = 1'b1;
  localparam logic PIX_WHITE = 1'b0;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/hack_word_fifo.sv
// Two-entry screen-word FIFO between the RAM fetch side and the pixel shifter.
module hack_word_fifo
  import hack_screen_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        push,
  input  word_t       din,
  input  logic        pop,
  output word_t       dout,
  output logic [1:0]  count
);

  word_t mem [2];
  logic  wr_ptr;
  logic  rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage carries no reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/hack_screen_scanout.sv
// Screen RAM reader and 1-bit pixel serialiser for the Hack 512x256 display.
// Optional build macro SCANOUT_UNDERRUN_CNT_EN adds the saturating underrun_cnt output.
module hack_screen_scanout
  import hack_screen_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int LINE_WORDS = WORDS_PER_LINE,
  parameter int LINES      = SCREEN_H
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              pix_ce,
  input  logic              active,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              pix_out,
  output logic              pix_valid,
  output logic              underrun
`ifdef SCANOUT_UNDERRUN_CNT_EN
  ,
  output logic [7:0]        underrun_cnt
`endif
);

  localparam int LINE_W = $clog2(LINES);
  localparam int WL_W   = $clog2(LINE_WORDS + 1);

  logic [LINE_W-1:0] line_idx;
  logic [LINE_W-1:0] cur_line;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] fetch_addr_nxt;
  logic [ADDR_W-1:0] line_base;
  logic [WL_W-1:0]   words_left;
  logic [WL_W-1:0]   words_left_nxt;
  logic [WL_W-1:0]   words_rem;
  logic              discard;
  logic              ack;
  logic              push;
  logic              pop;
  logic              issue;
  logic [1:0]        fifo_cnt;
  logic [1:0]        cnt_nxt;
  word_t             fifo_dout;
  word_t             shreg;
  logic [3:0]        bit_cnt;
  logic              starved;
  logic              pe;
  logic              need_load;
  logic              uevt;

  assign ack       = mem_req & mem_ack;
  assign pe        = pix_ce & active;
  assign need_load = (bit_cnt == 4'd0);
  assign cur_line  = frame_start ? '0 : line_idx;
  assign line_base = ADDR_W'(cur_line) * ADDR_W'(LINE_WORDS);
  assign push      = ack & ~discard & ~line_start;
  assign pop       = pe & ~line_start & need_load & (words_rem != '0) & ~starved & (fifo_cnt != 2'd0);
  assign uevt      = pe & ~line_start & need_load & (words_rem != '0) & ~starved & (fifo_cnt == 2'd0);

  // A new request may go out on the same edge that retires the previous one.
  always_comb begin
    fetch_addr_nxt = fetch_addr;
    words_left_nxt = words_left;
    if (line_start) begin
      fetch_addr_nxt = line_base;
      words_left_nxt = WL_W'(LINE_WORDS);
    end else if (push) begin
      fetch_addr_nxt = fetch_addr + ADDR_W'(1);
      words_left_nxt = words_left - WL_W'(1);
    end
    cnt_nxt = line_start ? 2'd0 : fifo_cnt + {1'b0, push} - {1'b0, pop};
    issue   = (!mem_req || ack) && (words_left_nxt != '0) && (cnt_nxt < 2'd2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fetch_addr <= '0;
      words_left <= '0;
      discard    <= 1'b0;
      line_idx   <= '0;
    end else begin
      fetch_addr <= fetch_addr_nxt;
      words_left <= words_left_nxt;
      if (issue) begin
        mem_req  <= 1'b1;
        mem_addr <= fetch_addr_nxt;
      end else if (ack) begin
        mem_req  <= 1'b0;
      end
      // A request still in flight across a line boundary belongs to the old line.
      if (line_start)  discard <= mem_req & ~mem_ack;
      else if (ack)    discard <= 1'b0;
      if (line_start)
        line_idx <= (cur_line == LINE_W'(LINES - 1)) ? '0 : cur_line + LINE_W'(1);
      else if (frame_start)
        line_idx <= '0;
    end
  end

  hack_word_fifo u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (line_start),
    .push    (push),
    .din     (mem_rdata),
    .pop     (pop),
    .dout    (fifo_dout),
    .count   (fifo_cnt)
  );

  // Shifter: first bit of a freshly loaded word goes straight to pix_out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= 4'd0;
      words_rem <= '0;
      starved   <= 1'b0;
      pix_out   <= PIX_WHITE;
      pix_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      pix_valid <= pe;
      if (line_start) begin
        bit_cnt   <= 4'd0;
        words_rem <= WL_W'(LINE_WORDS);
        starved   <= 1'b0;
        pix_out   <= PIX_WHITE;
      end else if (pe) begin
        if (!need_load) begin
          pix_out <= shreg[0];
          bit_cnt <= bit_cnt - 4'd1;
        end else if (pop) begin
          pix_out   <= fifo_dout[0];
          bit_cnt   <= 4'd15;
          words_rem <= words_rem - WL_W'(1);
        end else begin
          pix_out <= PIX_WHITE;
          if (uevt) starved <= 1'b1;
        end
      end
      if (frame_start) underrun <= 1'b0;
      else if (uevt)   underrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pe && !line_start) begin
      if (!need_load) shreg <= shreg >> 1;
      else if (pop)   shreg <= fifo_dout >> 1;
    end
  end

`ifdef SCANOUT_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          underrun_cnt <= 8'd0;
    else if (frame_start)                  underrun_cnt <= 8'd0;
    else if (uevt && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
  end
`endif

endmodule
